// File: rtl/controller_key_events.sv
// Per-key debounce with edge pulses, plus a shared auto-repeat sequencer for masked keys.
// The auto-repeat output is named repeat_out because "repeat" is a reserved word.
module controller_key_events #(
  parameter int              WIDTH           = 16,
  parameter int              DEBOUNCE_CYCLES = 16,
  parameter int              REPEAT_DELAY    = 24_000_000,
  parameter int              REPEAT_PERIOD   = 6_000_000,
  parameter logic [WIDTH-1:0] REPEAT_MASK    = 16'h000F
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_in,
  output logic [WIDTH-1:0] held,
  output logic [WIDTH-1:0] pressed,
  output logic [WIDTH-1:0] released,
  output logic [WIDTH-1:0] repeat_out
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = $clog2(TMR_MAX);

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [WIDTH-1:0]             sync1_q;
  logic [WIDTH-1:0]             sync_q;
  logic [WIDTH-1:0]             held_q, held_d;
  logic [WIDTH-1:0]             pressed_q, pressed_d;
  logic [WIDTH-1:0]             released_q, released_d;
  logic [WIDTH-1:0]             repeat_q, repeat_d;
  logic [WIDTH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  state_t                       state_q, state_d;
  logic [TMR_W-1:0]             timer_q, timer_d;
  logic [WIDTH-1:0]             mask_cur_s;
  logic [WIDTH-1:0]             mask_next_s;

  // Debounce: a bit flips only after CNT_LAST+1 consecutive cycles of disagreement.
  always_comb begin
    held_d = held_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_q[i] == held_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        held_d[i] = sync_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    pressed_d  = held_d & ~held_q;
    released_d = held_q & ~held_d;
  end

  // The sequencer looks at the next held value so its timer starts on the
  // same edge that held changes; a changed mask always wins over a due pulse.
  assign mask_cur_s  = held_q & REPEAT_MASK;
  assign mask_next_s = held_d & REPEAT_MASK;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    repeat_d = '0;
    if (mask_next_s != mask_cur_s) begin
      timer_d = '0;
      if (mask_next_s != '0) begin
        state_d = DELAY;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          timer_d = '0;
          if (mask_cur_s != '0) begin
            state_d = DELAY;
          end else begin
            state_d = IDLE;
          end
        end
        DELAY: begin
          if (timer_q == DELAY_LAST) begin
            repeat_d = mask_cur_s;
            state_d  = REPEAT;
            timer_d  = '0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        REPEAT: begin
          if (timer_q == PERIOD_LAST) begin
            repeat_d = mask_cur_s;
            timer_d  = '0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync_q     <= '0;
      held_q     <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      repeat_q   <= '0;
      cnt_q      <= '0;
      state_q    <= IDLE;
      timer_q    <= '0;
    end else begin
      sync1_q    <= key_in;
      sync_q     <= sync1_q;
      held_q     <= held_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      repeat_q   <= repeat_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
    end
  end

  assign held       = held_q;
  assign pressed    = pressed_q;
  assign released   = released_q;
  assign repeat_out = repeat_q;

endmodule

// File: tb/tb_controller_key_events.sv
// Bench for controller_key_events with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Cycle n means the state after the n-th rising edge following the first stimulus drive.
module tb_controller_key_events;

  logic        clk;
  logic        reset_n;
  logic [15:0] key_in;
  logic [15:0] held;
  logic [15:0] pressed;
  logic [15:0] released;
  logic [15:0] repeat_out;

  typedef struct { int scn; int cyc; logic [15:0] key; } stim_t;
  typedef struct { int scn; int cyc; logic [15:0] held; logic [15:0] pr; logic [15:0] rl; logic [15:0] rp; } evt_t;
  typedef struct { int scn; int cyc; logic [63:0] v; } exp_t;

  stim_t stims[$];
  evt_t  evts[$];
  exp_t  sb[$];
  int    n_vec = 0;
  int    n_err = 0;

  controller_key_events #(
    .WIDTH          (16),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .REPEAT_MASK    (16'h000F)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_in    (key_in),
    .held      (held),
    .pressed   (pressed),
    .released  (released),
    .repeat_out(repeat_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add_stim(int s, int c, logic [15:0] k);
    stim_t t;
    t.scn = s; t.cyc = c; t.key = k;
    stims.push_back(t);
  endfunction

  function automatic void add_evt(int s, int c, logic [15:0] h, logic [15:0] p, logic [15:0] r, logic [15:0] rp);
    evt_t t;
    t.scn = s; t.cyc = c; t.held = h; t.pr = p; t.rl = r; t.rp = rp;
    evts.push_back(t);
  endfunction

  function automatic logic [15:0] key_at(int s, int n);
    logic [15:0] k = 16'h0000;
    foreach (stims[i]) if (stims[i].scn == s && stims[i].cyc <= n) k = stims[i].key;
    return k;
  endfunction

  // Held persists from the latest event; pulses are zero except on an event cycle.
  function automatic exp_t exp_at(int s, int c);
    exp_t        e;
    logic [15:0] h  = 16'h0000;
    logic [15:0] p  = 16'h0000;
    logic [15:0] r  = 16'h0000;
    logic [15:0] rp = 16'h0000;
    foreach (evts[i]) begin
      if (evts[i].scn == s && evts[i].cyc <= c) h = evts[i].held;
      if (evts[i].scn == s && evts[i].cyc == c) begin
        p = evts[i].pr; r = evts[i].rl; rp = evts[i].rp;
      end
    end
    e.scn = s; e.cyc = c; e.v = {h, p, r, rp};
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (held,pressed,released,repeat)", name, act, expv);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk($sformatf("scn%0d_cyc%0d", e.scn, e.cyc), {held, pressed, released, repeat_out}, e.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    int scn_len[7] = '{20, 15, 40, 45, 22, 20, 16};
    int seen;
    reset_n = 1'b0;
    key_in  = 16'h0000;

    add_stim(0, 0, 16'h0010);
    add_stim(1, 0, 16'h0001); add_stim(1, 3, 16'h0000);
    add_stim(2, 0, 16'h0001); add_stim(2, 25, 16'h0000);
    add_stim(3, 0, 16'h0001); add_stim(3, 18, 16'h0003);
    add_stim(4, 0, 16'h0011);
    add_stim(5, 0, 16'h0030); add_stim(5, 8, 16'h0000);
    add_stim(6, 0, 16'h0100); add_stim(6, 4, 16'h0000);

    add_evt(0, 6, 16'h0010, 16'h0010, 16'h0000, 16'h0000);
    add_evt(2, 6, 16'h0001, 16'h0001, 16'h0000, 16'h0000);
    for (int c = 16; c <= 28; c += 3) add_evt(2, c, 16'h0001, 16'h0000, 16'h0000, 16'h0001);
    add_evt(2, 31, 16'h0000, 16'h0000, 16'h0001, 16'h0000);
    add_evt(3, 6, 16'h0001, 16'h0001, 16'h0000, 16'h0000);
    for (int c = 16; c <= 22; c += 3) add_evt(3, c, 16'h0001, 16'h0000, 16'h0000, 16'h0001);
    add_evt(3, 24, 16'h0003, 16'h0002, 16'h0000, 16'h0000);
    for (int c = 34; c <= 43; c += 3) add_evt(3, c, 16'h0003, 16'h0000, 16'h0000, 16'h0003);
    add_evt(4, 6, 16'h0011, 16'h0011, 16'h0000, 16'h0000);
    for (int c = 16; c <= 22; c += 3) add_evt(4, c, 16'h0011, 16'h0000, 16'h0000, 16'h0001);
    add_evt(5, 6, 16'h0030, 16'h0030, 16'h0000, 16'h0000);
    add_evt(5, 14, 16'h0000, 16'h0000, 16'h0030, 16'h0000);
    add_evt(6, 6, 16'h0100, 16'h0100, 16'h0000, 16'h0000);
    add_evt(6, 10, 16'h0000, 16'h0000, 16'h0100, 16'h0000);

    // Each scenario starts from reset; the cycle-0 key is already present as reset lifts.
    for (int s = 0; s < 7; s++) begin
      reset_n = 1'b0;
      key_in  = 16'h0000;
      repeat (3) @(negedge clk);
      chk($sformatf("reset_state_scn%0d", s), {held, pressed, released, repeat_out}, 64'd0);
      for (int n = 0; n < scn_len[s]; n++) begin
        key_in  = key_at(s, n);
        reset_n = 1'b1;
        sb.push_back(exp_at(s, n + 1));
        @(negedge clk);
      end
    end

    // Reset mid-DELAY: outputs clear at once and the pending repeat never fires.
    reset_n = 1'b0;
    key_in  = 16'h0000;
    repeat (2) @(negedge clk);
    key_in  = 16'h0001;
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("held_before_reset", {48'd0, held}, 64'd1);
    #2 reset_n = 1'b0;
    #1 chk("async_reset_clear", {held, pressed, released, repeat_out}, 64'd0);
    @(negedge clk) key_in = 16'h0000;
    @(negedge clk) reset_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      chk($sformatf("quiet_after_reset_c%0d", c), {held, pressed, released, repeat_out}, 64'd0);
    end
    key_in = 16'h0001;
    seen   = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (seen == 0 && pressed == 16'h0001) seen = c;
    end
    chk("fresh_press_cycle", 64'(seen), 64'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
